button_press_detector: RTL and testbench
========================================

# button_press_detector

Conditions a raw mechanical pushbutton into clean single-cycle events for downstream consumers such as LED timers and mode selectors. It sits between the board pin and any block that expects a one-clock `i_press` strobe. A two-flop synchronizer feeds a four-state debounce FSM, which reports press, release and held level. An optional long-press detector can be compiled in.

## Interface
- `DEBOUNCE_CYCLES`, default 500_000: consecutive stable synchronized cycles required to accept a level change (10 ms at 50 MHz); legal minimum 2.
- `LONG_PRESS_CYCLES`, default 50_000_000: held cycles, counted from the `o_press` cycle, before `o_long_press` fires (1 s at 50 MHz); legal minimum 2.
- `ACTIVE_LOW`, default 1: 1 means the pin reads 0 when pressed; 0 means it reads 1 when pressed.

- `i_clk`  input  1  system clock; all logic is on its rising edge.
- `i_rst_n`  input  1  asynchronous, active-low reset.
- `i_button`  input  1  raw pin, asynchronous to `i_clk`, may bounce.
- `o_press`  output  1  one-cycle pulse when a press is accepted.
- `o_release`  output  1  one-cycle pulse when a release is accepted.
- `o_level`  output  1  debounced pressed level; 1 while the button is considered held.
- `o_long_press`  output  1  one-cycle pulse once per press after a long hold; constant 0 when the feature is compiled out.

## Operation
- **Synchronizer:** two flops on `i_button`, then polarity normalization to `btn_s`, where 1 means pressed. Both flops reset to the pin's inactive level, so reset never produces a spurious press.
- **Debounce counter:** width `$clog2(DEBOUNCE_CYCLES)`. It is cleared on every state transition and never wraps.
- **FSM states and transitions:**
  - `S_IDLE`: on `btn_s`=1, go to `S_PRESS_WAIT` with the counter at 0.
  - `S_PRESS_WAIT`: counts while `btn_s`=1.
    - `btn_s`=0 at any count: return to `S_IDLE`, with no output.
    - Count reaching `DEBOUNCE_CYCLES-1` with `btn_s`=1: go to `S_HELD`, pulse `o_press`, set `o_level` to 1.
  - `S_HELD`: on `btn_s`=0, go to `S_RELEASE_WAIT` with the counter at 0.
  - `S_RELEASE_WAIT`: counts while `btn_s`=0.
    - `btn_s`=1 at any count: return to `S_HELD`, with no second `o_press`.
    - Count reaching `DEBOUNCE_CYCLES-1`: go to `S_IDLE`, pulse `o_release`, clear `o_level`.
- **Outputs:** all are registered. `o_press` and `o_release` are never high in the same cycle. A new `o_press` requires a full accepted release first.
- **Reset:** asserting `i_rst_n` low at any time, including mid-debounce, forces `S_IDLE`, clears the counters, and drives every output to 0 asynchronously. If the button is held through reset, it is re-detected as a fresh press after reset deasserts.

## Timing
- **Reset values:** `o_press`=0, `o_release`=0, `o_level`=0, `o_long_press`=0.
- **Press latency:** the raw pin is sampled as pressed at edge N and stays clean. `btn_s` goes high at edge N+2. `o_press` and `o_level` go high after edge N+1+`DEBOUNCE_CYCLES`, so `o_press` is visible in cycle N+`DEBOUNCE_CYCLES`+2 counting from 1.
- **Release latency:** symmetric with press latency; `o_level` falls in the same cycle that `o_release` pulses.
- **Glitch rejection:** any excursion of `btn_s` shorter than `DEBOUNCE_CYCLES` cycles produces no output.

## Configuration
- **Macro:** `BUTTON_PRESS_DETECTOR_LONG_PRESS_EN`.
- **Defined:**
  - A hold counter of width `$clog2(LONG_PRESS_CYCLES)+1` clears in the `o_press` cycle.
  - It increments in `S_HELD` and pauses in `S_RELEASE_WAIT`; it is cleared on entry to `S_IDLE` and on reset.
  - When the count reaches `LONG_PRESS_CYCLES`, `o_long_press` pulses for one cycle, i.e. `LONG_PRESS_CYCLES` cycles after `o_press`. The counter then saturates, so there is exactly one pulse per press.
- **Undefined:** the counter is not generated and `o_long_press` is tied to 0.

## Test plan
Scenarios 1-5 use `DEBOUNCE_CYCLES`=8, `LONG_PRESS_CYCLES`=32 and `ACTIVE_LOW`=1.
1. Pin driven 0 clean for 40 cycles from cycle 0, then 1 -> `o_press` is a single pulse in cycle 10, `o_level` is high from cycle 10, `o_release` is a single pulse 10 cycles after the pin returns to 1, and `o_level` is 0 from that cycle.
2. Pin driven with 0-pulses of 3, 5 and 7 cycles separated by 1s -> `o_press`, `o_level` and `o_release` stay 0 throughout.
3. With `o_level`=1, pin bounces high for 5 cycles then returns low -> no `o_release`, no second `o_press`, and `o_level` stays 1.
4. Held for 60 cycles with the macro defined -> exactly one `o_long_press` pulse, in cycle 42 (32 cycles after `o_press` in cycle 10). Same stimulus without the macro -> `o_long_press` stays 0.
5. `i_rst_n` pulled low in cycle 6 while the pin is held -> all outputs 0 immediately. With the pin still held, `o_press` appears 10 cycles after `i_rst_n` rises.
6. `ACTIVE_LOW`=0, `DEBOUNCE_CYCLES`=4: pin driven 1 for 10 cycles -> `o_press` in cycle 6, and no output while the pin idles at 0.

Source files
------------

// File: rtl/button_press_detector.sv
// Pushbutton conditioner: two-flop synchronizer, four-state debounce FSM, registered press/release/level strobes.
// Optional long-press pulse is compiled in with `define BUTTON_PRESS_DETECTOR_LONG_PRESS_EN.
module button_press_detector #(
    parameter int DEBOUNCE_CYCLES   = 500_000,
    parameter int LONG_PRESS_CYCLES = 50_000_000,
    parameter int ACTIVE_LOW        = 1
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_button,
    output logic o_press,
    output logic o_release,
    output logic o_level,
    output logic o_long_press
);

    localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES);
    // Entry into a wait state already consumes one stable sample, so the last count is D-2.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 2);
    localparam logic             PIN_IDLE = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

    typedef enum logic [1:0] {
        S_IDLE         = 2'b00,
        S_PRESS_WAIT   = 2'b01,
        S_HELD         = 2'b10,
        S_RELEASE_WAIT = 2'b11
    } state_t;

    logic             sync1_r;
    logic             sync2_r;
    logic             btn_s;
    state_t           state_r;
    state_t           state_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_s;
    logic             press_s;
    logic             release_s;
    logic             level_s;
    logic             press_r;
    logic             release_r;
    logic             level_r;

    // Metastability synchronizer, reset to the inactive pin level
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync1_r <= PIN_IDLE;
            sync2_r <= PIN_IDLE;
        end else begin
            sync1_r <= i_button;
            sync2_r <= sync1_r;
        end
    end

    assign btn_s = (ACTIVE_LOW != 0) ? ~sync2_r : sync2_r;

    // Debounce next-state, counter and strobe decode
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r;
        press_s   = 1'b0;
        release_s = 1'b0;
        level_s   = level_r;
        case (state_r)
            S_IDLE: begin
                cnt_s = {CNT_W{1'b0}};
                if (btn_s) begin
                    state_s = S_PRESS_WAIT;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_PRESS_WAIT: begin
                if (!btn_s) begin
                    state_s = S_IDLE;
                    cnt_s   = {CNT_W{1'b0}};
                end else if (cnt_r == CNT_LAST) begin
                    state_s = S_HELD;
                    cnt_s   = {CNT_W{1'b0}};
                    press_s = 1'b1;
                    level_s = 1'b1;
                end else begin
                    cnt_s = cnt_r + CNT_W'(1);
                end
            end
            S_HELD: begin
                cnt_s = {CNT_W{1'b0}};
                if (!btn_s) begin
                    state_s = S_RELEASE_WAIT;
                end else begin
                    state_s = S_HELD;
                end
            end
            S_RELEASE_WAIT: begin
                if (btn_s) begin
                    state_s = S_HELD;
                    cnt_s   = {CNT_W{1'b0}};
                end else if (cnt_r == CNT_LAST) begin
                    state_s   = S_IDLE;
                    cnt_s     = {CNT_W{1'b0}};
                    release_s = 1'b1;
                    level_s   = 1'b0;
                end else begin
                    cnt_s = cnt_r + CNT_W'(1);
                end
            end
            default: begin
                state_s = S_IDLE;
                cnt_s   = {CNT_W{1'b0}};
                level_s = 1'b0;
            end
        endcase
    end

    // FSM state, counter and registered outputs
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r   <= S_IDLE;
            cnt_r     <= {CNT_W{1'b0}};
            press_r   <= 1'b0;
            release_r <= 1'b0;
            level_r   <= 1'b0;
        end else begin
            state_r   <= state_s;
            cnt_r     <= cnt_s;
            press_r   <= press_s;
            release_r <= release_s;
            level_r   <= level_s;
        end
    end

    assign o_press   = press_r;
    assign o_release = release_r;
    assign o_level   = level_r;

`ifdef BUTTON_PRESS_DETECTOR_LONG_PRESS_EN
    localparam int                HOLD_W   = $clog2(LONG_PRESS_CYCLES) + 1;
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_PRESS_CYCLES);

    logic [HOLD_W-1:0] hold_r;
    logic [HOLD_W-1:0] hold_s;
    logic              long_s;
    logic              long_r;

    // Hold counter: runs while held, pauses during release debounce, saturates after one pulse
    always_comb begin
        hold_s = hold_r;
        long_s = 1'b0;
        case (state_r)
            S_HELD: begin
                if (hold_r != HOLD_MAX) begin
                    hold_s = hold_r + HOLD_W'(1);
                    long_s = (hold_r == (HOLD_MAX - HOLD_W'(1))) ? 1'b1 : 1'b0;
                end else begin
                    hold_s = hold_r;
                end
            end
            S_RELEASE_WAIT: begin
                if (state_s == S_IDLE) begin
                    hold_s = {HOLD_W{1'b0}};
                end else begin
                    hold_s = hold_r;
                end
            end
            default: begin
                hold_s = {HOLD_W{1'b0}};
            end
        endcase
    end

    // Long-press counter and pulse register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            hold_r <= {HOLD_W{1'b0}};
            long_r <= 1'b0;
        end else begin
            hold_r <= hold_s;
            long_r <= long_s;
        end
    end

    assign o_long_press = long_r;
`else
    assign o_long_press = 1'b0;
`endif

endmodule

// File: tb/tb_button_press_detector.sv
// Self-checking bench: two detector instances (active-low D=8, active-high D=4) against a streak-counting reference model.
module tb_button_press_detector;

    logic clk;
    logic rst_n;
    logic pin_a;
    logic pin_b;
    logic press_a, release_a, level_a, long_a;
    logic press_b, release_b, level_b, long_b;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit h1;
        bit h2;
        int level;
        int run;
        int hold;
        bit press;
        bit rel;
        bit longp;
    } mdl_t;

    mdl_t ma;
    mdl_t mb;

    button_press_detector #(.DEBOUNCE_CYCLES(8), .LONG_PRESS_CYCLES(32), .ACTIVE_LOW(1)) dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_button(pin_a),
        .o_press(press_a), .o_release(release_a), .o_level(level_a), .o_long_press(long_a)
    );

    button_press_detector #(.DEBOUNCE_CYCLES(4), .LONG_PRESS_CYCLES(8), .ACTIVE_LOW(0)) dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_button(pin_b),
        .o_press(press_b), .o_release(release_b), .o_level(level_b), .o_long_press(long_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic mdl_t mdl_reset();
        mdl_t m;
        m.h1 = 1'b0; m.h2 = 1'b0; m.level = 0; m.run = 0; m.hold = 0;
        m.press = 1'b0; m.rel = 1'b0; m.longp = 1'b0;
        return m;
    endfunction

    // A level change is accepted after d consecutive synchronized samples that disagree with it.
    function automatic mdl_t mdl_step(mdl_t m_in, bit pressed, int d, int l);
        mdl_t m;
        bit   seen;
        bit   was_held;
        m       = m_in;
        seen    = m.h2;
        m.h2    = m.h1;
        m.h1    = pressed;
        m.press = 1'b0;
        m.rel   = 1'b0;
        m.longp = 1'b0;
        was_held = (m.level == 1) && (m.run == 0);
        if (int'(seen) != m.level) m.run = m.run + 1;
        else m.run = 0;
        if (m.run == d) begin
            m.level = 1 - m.level;
            m.run   = 0;
            m.hold  = 0;
            if (m.level == 1) m.press = 1'b1;
            else m.rel = 1'b1;
        end else begin
`ifdef BUTTON_PRESS_DETECTOR_LONG_PRESS_EN
            if (was_held && m.hold < l) begin
                m.hold = m.hold + 1;
                if (m.hold == l) m.longp = 1'b1;
            end
`else
            if (was_held && m.hold < l) m.hold = m.hold;
`endif
        end
        return m;
    endfunction

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".a.press"},   press_a,   ma.press);
        chk({tag, ".a.release"}, release_a, ma.rel);
        chk({tag, ".a.level"},   level_a,   ma.level[0]);
        chk({tag, ".a.long"},    long_a,    ma.longp);
        chk({tag, ".b.press"},   press_b,   mb.press);
        chk({tag, ".b.release"}, release_b, mb.rel);
        chk({tag, ".b.level"},   level_b,   mb.level[0]);
        chk({tag, ".b.long"},    long_b,    mb.longp);
    endtask

    // One clock: advance the model on the rising edge, compare on the falling edge.
    task automatic tick(input string tag);
        @(posedge clk);
        if (rst_n) begin
            ma = mdl_step(ma, !pin_a, 8, 32);
            mb = mdl_step(mb, pin_b, 4, 8);
        end else begin
            ma = mdl_reset();
            mb = mdl_reset();
        end
        @(negedge clk);
        check_all(tag);
    endtask

    initial begin
        int ra;
        int rb;
        int long_seen;
        rst_n = 1'b0;
        pin_a = 1'b1;
        pin_b = 1'b0;
        ma = mdl_reset();
        mb = mdl_reset();
        repeat (3) @(negedge clk);
        check_all("reset");

        // Scenarios 1, 4 and 6: clean press from cycle 0 on both instances
        rst_n = 1'b1;
        pin_a = 1'b0;
        pin_b = 1'b1;
        long_seen = 0;
        for (int c = 1; c <= 60; c++) begin
            if (c == 11) pin_b = 1'b0;
            tick("clean");
            if (c == 6)  chk("b.press_cycle6", press_b, 1'b1);
            if (c == 9)  chk("a.no_press_cycle9", press_a, 1'b0);
            if (c == 10) chk("a.press_cycle10", press_a, 1'b1);
            if (c == 10) chk("a.level_cycle10", level_a, 1'b1);
            if (long_a === 1'b1) long_seen++;
`ifdef BUTTON_PRESS_DETECTOR_LONG_PRESS_EN
            if (c == 42) chk("a.long_cycle42", long_a, 1'b1);
`endif
        end
`ifdef BUTTON_PRESS_DETECTOR_LONG_PRESS_EN
        chk("a.long_once", (long_seen == 1) ? 1'b1 : 1'b0, 1'b1);
`else
        chk("a.long_never", (long_seen == 0) ? 1'b1 : 1'b0, 1'b1);
`endif

        // Scenario 3: bounce high for 5 cycles while held
        pin_a = 1'b1;
        repeat (5) tick("bounce");
        pin_a = 1'b0;
        repeat (12) tick("bounce_back");
        chk("a.level_after_bounce", level_a, 1'b1);

        // Scenario 1 tail: release accepted 10 cycles after the pin returns high
        pin_a = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            tick("release");
            if (c == 10) chk("a.release_cycle10", release_a, 1'b1);
            if (c == 10) chk("a.level_low_cycle10", level_a, 1'b0);
        end

        // Scenario 2: short low pulses of 3, 5 and 7 cycles
        for (int g = 3; g <= 7; g += 2) begin
            pin_a = 1'b0;
            repeat (g) tick("glitch_lo");
            pin_a = 1'b1;
            tick("glitch_hi");
        end
        repeat (10) tick("glitch_idle");
        chk("a.level_after_glitch", level_a, 1'b0);

        // Scenario 5: reset while held, then re-detection with the pin still held
        pin_a = 1'b0;
        repeat (14) tick("pre_reset");
        chk("a.level_before_reset", level_a, 1'b1);
        rst_n = 1'b0;
        #1;
        ma = mdl_reset();
        mb = mdl_reset();
        check_all("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            tick("post_reset");
            if (c == 10) chk("a.press_after_reset", press_a, 1'b1);
        end

        // Randomized runs of varied length on both pins
        ra = 0;
        rb = 0;
        for (int i = 0; i < 3000; i++) begin
            if (ra == 0) begin
                pin_a = ~pin_a;
                ra = ($urandom_range(0, 2) == 0) ? int'($urandom_range(20, 60)) : int'($urandom_range(1, 10));
            end
            if (rb == 0) begin
                pin_b = ~pin_b;
                rb = ($urandom_range(0, 2) == 0) ? int'($urandom_range(6, 20)) : int'($urandom_range(1, 5));
            end
            ra--;
            rb--;
            tick("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
